// File: rtl/ysyx_25040111_scoreboard_pkg.sv
// Shared defaults and helpers for the register-hazard scoreboard.
package ysyx_25040111_scoreboard_pkg;

  localparam int unsigned SB_NREG   = 16;
  localparam int unsigned SB_CNT_W  = 2;
  localparam int unsigned SB_NFIN   = 2;
  localparam bit          SB_BYPASS = 1'b1;

  // Width able to hold 0..nfin simultaneous finishes on one register.
  function automatic int unsigned hit_w(input int unsigned nfin);
    return $clog2(nfin + 1);
  endfunction

endpackage

// File: rtl/ysyx_25040111_scoreboard_if.sv
// Issue / finish / status bundle between the execute stage and the scoreboard.
interface ysyx_25040111_scoreboard_if
  import ysyx_25040111_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = SB_NREG,
  parameter int unsigned NFIN = SB_NFIN
) ();

  localparam int unsigned AW = $clog2(NREG);

  logic                 iss_valid;
  logic                 iss_ready;
  logic [AW-1:0]        iss_rd;
  logic [AW-1:0]        iss_rs1;
  logic [AW-1:0]        iss_rs2;
  logic                 iss_lock;
  logic [NFIN-1:0]      fin_valid;
  logic [NFIN*AW-1:0]   fin_rd;
  logic [NREG-1:0]      pend_vec;
  logic                 busy;
  logic                 err;

  modport master (
    output iss_valid, iss_rd, iss_rs1, iss_rs2, iss_lock, fin_valid, fin_rd,
    input  iss_ready, pend_vec, busy, err
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rs1, iss_rs2, iss_lock, fin_valid, fin_rd,
    output iss_ready, pend_vec, busy, err
  );

endinterface

// File: rtl/ysyx_25040111_sb_cnt.sv
// One register's pending-write counter: +1 on locked issue, -hits on finishes,
// clamps at zero and flags the underflow for the sticky error.
module ysyx_25040111_sb_cnt #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned HW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic [HW-1:0]    dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             pend_o,
  output logic             uflow_o
);

  localparam int unsigned SW = ((CNT_W + 1) > HW) ? (CNT_W + 1) : HW;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q;
  logic [SW-1:0]    sum_c;

  always_comb begin
    sum_c   = SW'(cnt_q) + SW'(inc_i);
    uflow_o = SW'(dec_i) > sum_c;
    cnt_d   = uflow_o ? '0 : CNT_W'(sum_c - SW'(dec_i));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= (cnt_d != '0);
    end
  end

  assign cnt_o  = cnt_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/ysyx_25040111_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write counts gate issue on
// RAW/WAW hazards; any finish port releases a count, optionally in the same cycle.
module ysyx_25040111_scoreboard
  import ysyx_25040111_scoreboard_pkg::*;
#(
  parameter int unsigned NREG   = SB_NREG,
  parameter int unsigned CNT_W  = SB_CNT_W,
  parameter int unsigned NFIN   = SB_NFIN,
  parameter bit          BYPASS = SB_BYPASS
) (
  input logic                        clock,
  input logic                        reset,
  ysyx_25040111_scoreboard_if.slave  sb
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned HW = hit_w(NFIN);
  localparam int unsigned SW = ((CNT_W + 1) > HW) ? (CNT_W + 1) : HW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt   [NREG];
  logic [HW-1:0]    hits  [NREG];
  logic [NREG-1:0]  eff_nz_c;
  logic [NREG-1:0]  pend;
  logic [NREG-1:0]  uflow_c;
  logic             hazard_c, full_c, fire_c;
  logic             err_q, err_d;

  // Number of finish ports retiring each register this cycle; x0 never counts.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      hits[r] = '0;
      for (int k = 0; k < NFIN; k++) begin
        if (r != 0 && sb.fin_valid[k] && sb.fin_rd[k*AW +: AW] == AW'(r))
          hits[r] = hits[r] + HW'(1);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      eff_nz_c[r] = BYPASS ? (SW'(cnt[r]) > SW'(hits[r])) : (cnt[r] != '0);
    end
  end

  always_comb begin
    hazard_c = eff_nz_c[sb.iss_rs1] | eff_nz_c[sb.iss_rs2] | eff_nz_c[sb.iss_rd];
    full_c   = sb.iss_lock && (cnt[sb.iss_rd] == CNT_MAX) && (hits[sb.iss_rd] == '0);
    fire_c   = sb.iss_valid && !hazard_c && !full_c;
  end

  assign sb.iss_ready = ~hazard_c & ~full_c;

  // Register 0 is hard-wired idle; the rest each get a counter.
  assign cnt[0]     = '0;
  assign pend[0]    = 1'b0;
  assign uflow_c[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    ysyx_25040111_sb_cnt #(
      .CNT_W (CNT_W),
      .HW    (HW)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (fire_c && sb.iss_lock && (sb.iss_rd == AW'(r))),
      .dec_i   (hits[r]),
      .cnt_o   (cnt[r]),
      .pend_o  (pend[r]),
      .uflow_o (uflow_c[r])
    );
  end

  assign err_d = err_q | (|uflow_c);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign sb.pend_vec = pend;
  assign sb.busy     = |pend;
  assign sb.err      = err_q;

endmodule

// File: tb/tb_ysyx_25040111_scoreboard.sv
// Drives a bypass and a non-bypass scoreboard with identical stimulus and checks
// both against an array-based model of the pending-write counts.
module tb_ysyx_25040111_scoreboard;
  import ysyx_25040111_scoreboard_pkg::*;

  localparam int NREG  = int'(SB_NREG);
  localparam int NFIN  = int'(SB_NFIN);
  localparam int CNT_W = int'(SB_CNT_W);
  localparam int AW    = $clog2(NREG);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_25040111_scoreboard_if #(.NREG(SB_NREG), .NFIN(SB_NFIN)) if_b ();
  ysyx_25040111_scoreboard_if #(.NREG(SB_NREG), .NFIN(SB_NFIN)) if_n ();

  ysyx_25040111_scoreboard #(.BYPASS(1'b1)) u_dut_b (.clock(clock), .reset(reset), .sb(if_b.slave));
  ysyx_25040111_scoreboard #(.BYPASS(1'b0)) u_dut_n (.clock(clock), .reset(reset), .sb(if_n.slave));

  assign if_n.iss_valid = if_b.iss_valid;
  assign if_n.iss_rd    = if_b.iss_rd;
  assign if_n.iss_rs1   = if_b.iss_rs1;
  assign if_n.iss_rs2   = if_b.iss_rs2;
  assign if_n.iss_lock  = if_b.iss_lock;
  assign if_n.fin_valid = if_b.fin_valid;
  assign if_n.fin_rd    = if_b.fin_rd;

  // Model state: index 0 = bypass DUT, index 1 = non-bypass DUT.
  int cnt_m [2][NREG];
  bit err_m [2];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hits_m(input int r);
    int h = 0;
    for (int k = 0; k < NFIN; k++)
      if (r != 0 && if_b.fin_valid[k] && int'(if_b.fin_rd[k*AW +: AW]) == r) h++;
    return h;
  endfunction

  function automatic bit blocks(input int d, input int r);
    int e = cnt_m[d][r];
    if (d == 0) e = e - hits_m(r);
    return e > 0;
  endfunction

  function automatic bit ready_m(input int d);
    int rd = int'(if_b.iss_rd);
    bit haz  = blocks(d, int'(if_b.iss_rs1)) || blocks(d, int'(if_b.iss_rs2)) || blocks(d, rd);
    bit full = if_b.iss_lock && cnt_m[d][rd] == CMAX && hits_m(rd) == 0;
    return !haz && !full;
  endfunction

  function automatic logic [31:0] pend_m(input int d);
    logic [31:0] p = '0;
    for (int r = 0; r < NREG; r++) p[r] = (cnt_m[d][r] != 0);
    return p;
  endfunction

  function automatic logic [31:0] dut_ready(input int d);
    return (d == 0) ? 32'(if_b.iss_ready) : 32'(if_n.iss_ready);
  endfunction
  function automatic logic [31:0] dut_pend(input int d);
    return (d == 0) ? 32'(if_b.pend_vec) : 32'(if_n.pend_vec);
  endfunction
  function automatic logic [31:0] dut_busy(input int d);
    return (d == 0) ? 32'(if_b.busy) : 32'(if_n.busy);
  endfunction
  function automatic logic [31:0] dut_err(input int d);
    return (d == 0) ? 32'(if_b.err) : 32'(if_n.err);
  endfunction

  task automatic drive(input bit v, input int rd, input int rs1, input int rs2, input bit lock,
                       input bit [1:0] fv, input int f0, input int f1);
    if_b.iss_valid = v;
    if_b.iss_rd    = AW'(rd);
    if_b.iss_rs1   = AW'(rs1);
    if_b.iss_rs2   = AW'(rs2);
    if_b.iss_lock  = lock;
    if_b.fin_valid = fv;
    if_b.fin_rd    = {AW'(f1), AW'(f0)};
  endtask

  task automatic check_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_pend_d%0d", tag, d), dut_pend(d), pend_m(d));
      check($sformatf("%s_busy_d%0d", tag, d), dut_busy(d), 32'(pend_m(d) != 0));
      check($sformatf("%s_err_d%0d", tag, d), dut_err(d), 32'(err_m[d]));
    end
  endtask

  // One clock: check ready against the model, then advance model and check status.
  task automatic tick(input string tag);
    bit fire [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      bit rdy = ready_m(d);
      check($sformatf("%s_ready_d%0d", tag, d), dut_ready(d), 32'(rdy));
      fire[d] = if_b.iss_valid && rdy;
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NREG; r++) begin
        int inc = (fire[d] && if_b.iss_lock && int'(if_b.iss_rd) == r && r != 0) ? 1 : 0;
        int v   = cnt_m[d][r] + inc - hits_m(r);
        if (v < 0) begin
          v = 0;
          err_m[d] = 1'b1;
        end
        cnt_m[d][r] = v;
      end
    end
    #1;
    check_outputs(tag);
    @(negedge clock);
  endtask

  // Asynchronous reset mid-cycle: state must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_rst_pend_d%0d", tag, d), dut_pend(d), 32'd0);
      check($sformatf("%s_rst_busy_d%0d", tag, d), dut_busy(d), 32'd0);
      check($sformatf("%s_rst_err_d%0d", tag, d), dut_err(d), 32'd0);
      check($sformatf("%s_rst_ready_d%0d", tag, d), dut_ready(d), 32'd1);
      err_m[d] = 1'b0;
      for (int r = 0; r < NREG; r++) cnt_m[d][r] = 0;
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int d = 0; d < 2; d++) begin
      err_m[d] = 1'b0;
      for (int r = 0; r < NREG; r++) cnt_m[d][r] = 0;
    end
    #2;
    check_outputs("por");
    check("por_ready_b", dut_ready(0), 32'd1);
    check("por_ready_n", dut_ready(1), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // RAW on a locked load destination, released by a finish
    drive(1, 5, 0, 0, 1, 2'b00, 0, 0); tick("t2_lock");
    drive(1, 1, 5, 0, 0, 2'b00, 0, 0);
    #1; check("t2_stall_b", dut_ready(0), 32'd0); check("t2_stall_n", dut_ready(1), 32'd0);
    tick("t2_stall");
    drive(1, 1, 5, 0, 0, 2'b01, 5, 0);
    #1; check("t2_byp_b", dut_ready(0), 32'd1); check("t2_byp_n", dut_ready(1), 32'd0);
    tick("t2_fin");
    drive(1, 1, 5, 0, 0, 2'b00, 0, 0);
    #1; check("t2_late_n", dut_ready(1), 32'd1);
    tick("t2_after");

    // Async reset with locks pending and the error flag set
    drive(1, 5, 0, 0, 1, 2'b00, 0, 0); tick("t1_lock5");
    drive(1, 6, 0, 0, 1, 2'b00, 0, 0); tick("t1_lock6");
    drive(0, 0, 0, 0, 0, 2'b01, 2, 0); tick("t1_uflow");
    check("t1_err_set", dut_err(0), 32'd1);
    do_reset("t1");

    // Repeated locks on one register are WAW-gated
    for (int i = 0; i < 4; i++) begin
      drive(1, 7, 0, 0, 1, 2'b00, 0, 0); tick($sformatf("t3_lock%0d", i));
    end
    drive(1, 7, 0, 0, 1, 2'b00, 0, 0);
    #1; check("t3_full_b", dut_ready(0), 32'd0); check("t3_full_n", dut_ready(1), 32'd0);
    drive(1, 7, 0, 0, 1, 2'b01, 7, 0);
    #1; check("t3_rel_b", dut_ready(0), 32'd1); check("t3_rel_n", dut_ready(1), 32'd0);
    tick("t3_rel");
    check("t3_pend7_b", 32'(if_b.pend_vec[7]), 32'd1);
    check("t3_pend7_n", 32'(if_n.pend_vec[7]), 32'd0);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    do_reset("t3");

    // Issue-lock and finish of the same register in one cycle
    drive(1, 3, 0, 0, 1, 2'b00, 0, 0); tick("t4_lock");
    drive(1, 3, 0, 0, 1, 2'b10, 0, 3); tick("t4_same");
    check("t4_pend3_b", 32'(if_b.pend_vec[3]), 32'd1);
    check("t4_pend3_n", 32'(if_n.pend_vec[3]), 32'd0);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    do_reset("t4");

    // Both ports finishing in one cycle
    drive(1, 9, 0, 0, 1, 2'b00, 0, 0);  tick("t5_lock9");
    drive(1, 10, 0, 0, 1, 2'b00, 0, 0); tick("t5_lock10");
    drive(0, 0, 0, 0, 0, 2'b11, 9, 10); tick("t5_fin");
    check("t5_busy", dut_busy(0), 32'd0);
    check("t5_err", dut_err(0), 32'd0);

    // Sticky underflow error and register 0 never locking
    drive(0, 0, 0, 0, 0, 2'b01, 4, 0); tick("t6_uflow");
    check("t6_err_b", dut_err(0), 32'd1);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0); tick("t6_hold");
    check("t6_err_hold_n", dut_err(1), 32'd1);
    drive(1, 0, 0, 0, 1, 2'b00, 0, 0); tick("t6_x0");
    check("t6_pend0", 32'(if_b.pend_vec[0]), 32'd0);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    do_reset("t6");

    // Two ports retiring the same register with a single pending write
    drive(1, 9, 0, 0, 1, 2'b00, 0, 0); tick("t7_lock");
    drive(0, 0, 0, 0, 0, 2'b11, 9, 9); tick("t7_dual");
    check("t7_pend9", 32'(if_b.pend_vec[9]), 32'd0);
    check("t7_err", dut_err(0), 32'd1);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    do_reset("t7");

    // Randomised traffic on a small register window to force collisions
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        do_reset("rnd");
      end else begin
        drive(($urandom_range(0, 9) < 8),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 1) == 1),
              {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0)},
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        tick("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
